// File: rtl/assembly_test_monitor_pkg.sv
// Shared definitions for the assembly self-test monitor.
// Holds the verdict error codes, the monitor state encoding and the
// default sentinel instruction (ebreak) that marks the end of a test program.
package assembly_test_monitor_pkg;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_MISMATCH   = 3'd1;
    localparam logic [2:0] ERR_TAKEOVER   = 3'd2;
    localparam logic [2:0] ERR_INCOMPLETE = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
    localparam logic [2:0] ERR_STALL      = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } mon_state_t;

    localparam logic [31:0] DEFAULT_END_INSTR = 32'h0010_0073;

endpackage

// File: rtl/assembly_test_monitor_watchdog.sv
// Stall watchdog for the assembly test monitor.
// Counts consecutive enabled cycles, saturating at STALL_LIMIT, and is
// cleared whenever the CPU retires. 'expired' is combinational and flags
// the cycle that brings the count up to STALL_LIMIT, so the parent can
// register the verdict at the edge ending that cycle.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-low reset
//   clear   - zero the counter (takes precedence over enable)
//   enable  - count this cycle
//   expired - this enabled cycle is the STALL_LIMIT-th in a row
// STALL_LIMIT == 0 disables the watchdog entirely.
module assembly_test_watchdog #(
    parameter int STALL_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(STALL_LIMIT))) begin
            count <= count + CW'(1);
        end
    end

    // The current cycle is included in the tally, hence the LIMIT-1 compare.
    generate
        if (STALL_LIMIT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            assign expired = enable && !clear && (count >= CW'(STALL_LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/assembly_test_monitor.sv
// In-SoC checker for assembly self-tests.
// Snoops the register-file write port and the retire strobe, keeps shadow
// copies of the test-number, result, benchmark and check registers, and
// issues a sticky verdict.
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-low reset
//   rf_we/rf_waddr/rf_wdata - register-file write port
//   retire/instr/pc         - retiring instruction and its PC
//   done/pass/fail          - verdict flags (sticky)
//   err_code                - 0 none, 1 mismatch, 2 takeover, 3 incomplete,
//                             4 timeout, 5 stall
//   fail_test/fail_pc       - test number and PC at the failure
//   test_count              - distinct sub-tests entered
//   retired_count           - instructions retired
module assembly_test_monitor
    import assembly_test_monitor_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          TEST_REG    = 1,
    parameter int          RESULT_REG  = 29,
    parameter int          BENCH_REG   = 30,
    parameter int          CHECK_REG   = 31,
    parameter int          MAX_RETIRED = 1024,
    parameter int          STALL_LIMIT = 16,
    parameter logic [31:0] END_INSTR   = DEFAULT_END_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            retire,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [2:0]      err_code,
    output logic [XLEN-1:0] fail_test,
    output logic [XLEN-1:0] fail_pc,
    output logic [15:0]     test_count,
    output logic [XLEN-1:0] retired_count
);

    localparam logic [4:0] TEST_IDX   = 5'(TEST_REG);
    localparam logic [4:0] RESULT_IDX = 5'(RESULT_REG);
    localparam logic [4:0] BENCH_IDX  = 5'(BENCH_REG);
    localparam logic [4:0] CHECK_IDX  = 5'(CHECK_REG);

    mon_state_t state_q, state_d;
    logic [2:0] err_d;

    logic [XLEN-1:0] test_q, result_q, bench_q, check_q;
    logic [XLEN-1:0] test_n, result_n, bench_n, check_n;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] retired_inc;
    logic hit_test, hit_result, hit_bench, hit_check;
    logic is_end, takeover, mismatch, incomplete, timeout;
    logic stall_expired;

    // An index of 0 aliases x0, whose writes are discarded, so that shadow
    // never leaves zero.
    assign hit_test   = rf_we && (rf_waddr == TEST_IDX)   && (TEST_IDX   != 5'd0);
    assign hit_result = rf_we && (rf_waddr == RESULT_IDX) && (RESULT_IDX != 5'd0);
    assign hit_bench  = rf_we && (rf_waddr == BENCH_IDX)  && (BENCH_IDX  != 5'd0);
    assign hit_check  = rf_we && (rf_waddr == CHECK_IDX)  && (CHECK_IDX  != 5'd0);

    // Same-cycle writes are merged so a retiring instruction that writes the
    // check register is judged against its own result.
    assign test_n   = hit_test   ? rf_wdata : test_q;
    assign result_n = hit_result ? rf_wdata : result_q;
    assign bench_n  = hit_bench  ? rf_wdata : bench_q;
    assign check_n  = hit_check  ? rf_wdata : check_q;

    assign retired_inc = retired_count + XLEN'(1);
    assign is_end      = (instr == END_INSTR);
    assign takeover    = (check_n != '0) && (check_n != test_n);
    assign mismatch    = (check_n != '0) && (check_n == test_n) && (result_n !== bench_n);
    assign incomplete  = is_end && (test_n != '0) && (check_n != test_n);
    assign timeout     = !is_end && (retired_inc >= XLEN'(MAX_RETIRED));

    assembly_test_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (retire || (state_q != RUN)),
        .enable  ((state_q == RUN) && !retire),
        .expired (stall_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Checks only run on retire cycles; the watchdog only fires on idle ones,
    // so STALL never competes with the retire-time errors.
    always_comb begin
        state_d = state_q;
        err_d   = ERR_NONE;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (retire) begin
                    if (takeover)        err_d = ERR_TAKEOVER;
                    else if (mismatch)   err_d = ERR_MISMATCH;
                    else if (incomplete) err_d = ERR_INCOMPLETE;
                    else if (timeout)    err_d = ERR_TIMEOUT;
                    if (err_d != ERR_NONE) state_d = FAIL;
                    else if (is_end)       state_d = PASS;
                end else if (stall_expired) begin
                    err_d   = ERR_STALL;
                    state_d = FAIL;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Shadows, counters and failure capture move only while running, which
    // freezes everything once a verdict is reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            test_q        <= '0;
            result_q      <= '0;
            bench_q       <= '0;
            check_q       <= '0;
            last_pc       <= '0;
            err_code      <= ERR_NONE;
            fail_test     <= '0;
            fail_pc       <= '0;
            test_count    <= '0;
            retired_count <= '0;
        end else if (state_q == RUN) begin
            test_q   <= test_n;
            result_q <= result_n;
            bench_q  <= bench_n;
            check_q  <= check_n;
            if (retire) begin
                retired_count <= retired_inc;
                last_pc       <= pc;
                if (hit_test && (test_n != test_q) && (test_count != 16'hFFFF)) begin
                    test_count <= test_count + 16'd1;
                end
            end
            if (state_d == FAIL) begin
                err_code  <= err_d;
                fail_test <= test_n;
                fail_pc   <= retire ? pc : last_pc;
            end
        end
    end

    assign done = (state_q == PASS) || (state_q == FAIL);
    assign pass = (state_q == PASS);
    assign fail = (state_q == FAIL);

endmodule

// File: tb/tb_assembly_test_monitor.sv
// Directed self-checking bench for assembly_test_monitor, built with
// STALL_LIMIT=4 and MAX_RETIRED=8 so the watchdog and retire budget are
// reachable with short programs.
module tb_assembly_test_monitor;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        done, pass, fail;
    logic [2:0]  err_code;
    logic [31:0] fail_test, fail_pc;
    logic [15:0] test_count;
    logic [31:0] retired_count;

    int n_pass  = 0;
    int n_total = 0;

    assembly_test_monitor #(
        .XLEN        (32),
        .MAX_RETIRED (8),
        .STALL_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire        (retire),
        .instr         (instr),
        .pc            (pc),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .err_code      (err_code),
        .fail_test     (fail_test),
        .fail_pc       (fail_pc),
        .test_count    (test_count),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One clock of activity; inputs return to idle afterwards.
    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic ret, input logic [31:0] ins, input logic [31:0] p);
        rf_we = we; rf_waddr = a; rf_wdata = d; retire = ret; instr = ins; pc = p;
        cycle();
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = '0; retire = 1'b0; instr = NOP; pc = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle();
        n_total++; if ({done, pass, fail} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {done, pass, fail}); else n_pass++;
        n_total++; if (err_code !== 3'd0) $display("[TB] FAIL reset_err: got %0d expected 0", err_code); else n_pass++;
        n_total++; if ({fail_test, fail_pc} !== 64'd0) $display("[TB] FAIL reset_fail_info: got %0h/%0h expected 0/0", fail_test, fail_pc); else n_pass++;
        n_total++; if ({test_count, retired_count} !== 48'd0) $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", test_count, retired_count); else n_pass++;
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_pass();
        do_reset();
        drive(1, 5'd1, 32'd1, 1, NOP, 32'h0);
        drive(1, 5'd29, 32'd5, 1, NOP, 32'h4);
        drive(1, 5'd30, 32'd5, 1, NOP, 32'h8);
        drive(1, 5'd31, 32'd1, 1, NOP, 32'hC);
        n_total++; if (done !== 1'b0) $display("[TB] FAIL pass_not_done_early: got %b expected 0", done); else n_pass++;
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h10);
        n_total++; if ({done, pass, fail} !== 3'b110) $display("[TB] FAIL pass_flags: got %b expected 110", {done, pass, fail}); else n_pass++;
        n_total++; if (err_code !== 3'd0) $display("[TB] FAIL pass_err: got %0d expected 0", err_code); else n_pass++;
        n_total++; if (test_count !== 16'd1) $display("[TB] FAIL pass_test_count: got %0d expected 1", test_count); else n_pass++;
        n_total++; if (retired_count !== 32'd5) $display("[TB] FAIL pass_retired: got %0d expected 5", retired_count); else n_pass++;
    endtask

    task automatic test_mismatch();
        do_reset();
        drive(1, 5'd1, 32'd3, 1, NOP, 32'h0);
        drive(1, 5'd29, 32'd7, 1, NOP, 32'h4);
        drive(1, 5'd30, 32'd8, 1, NOP, 32'h8);
        drive(1, 5'd31, 32'd3, 1, NOP, 32'h40);
        n_total++; if ({done, pass, fail} !== 3'b101) $display("[TB] FAIL mismatch_flags: got %b expected 101", {done, pass, fail}); else n_pass++;
        n_total++; if (err_code !== 3'd1) $display("[TB] FAIL mismatch_err: got %0d expected 1", err_code); else n_pass++;
        n_total++; if (fail_test !== 32'd3) $display("[TB] FAIL mismatch_fail_test: got %0d expected 3", fail_test); else n_pass++;
        n_total++; if (fail_pc !== 32'h40) $display("[TB] FAIL mismatch_fail_pc: got %0h expected 40", fail_pc); else n_pass++;
        drive(1, 5'd30, 32'd7, 1, NOP, 32'h44);
        drive(1, 5'd1, 32'd9, 1, EBRK, 32'h48);
        n_total++; if ({pass, fail, err_code} !== 5'b01_001) $display("[TB] FAIL mismatch_sticky: got %b expected 01001", {pass, fail, err_code}); else n_pass++;
        n_total++; if ({fail_test, fail_pc} !== {32'd3, 32'h40}) $display("[TB] FAIL mismatch_sticky_info: got %0h/%0h expected 3/40", fail_test, fail_pc); else n_pass++;
        n_total++; if ({test_count, retired_count} !== {16'd1, 32'd4}) $display("[TB] FAIL mismatch_frozen: got %0d/%0d expected 1/4", test_count, retired_count); else n_pass++;
    endtask

    task automatic test_takeover();
        do_reset();
        drive(1, 5'd1, 32'd2, 1, NOP, 32'h0);
        drive(1, 5'd29, 32'd1, 1, NOP, 32'h4);
        drive(1, 5'd30, 32'd9, 1, NOP, 32'h8);
        drive(1, 5'd31, 32'd4, 1, NOP, 32'hC);
        n_total++; if (err_code !== 3'd2) $display("[TB] FAIL takeover_err: got %0d expected 2", err_code); else n_pass++;
        n_total++; if ({fail, fail_test, fail_pc} !== {1'b1, 32'd2, 32'hC}) $display("[TB] FAIL takeover_info: got %b/%0h/%0h expected 1/2/c", fail, fail_test, fail_pc); else n_pass++;
        // Matching check number in the same cycle exposes the mismatch instead.
        do_reset();
        drive(1, 5'd1, 32'd2, 1, NOP, 32'h0);
        drive(1, 5'd29, 32'd1, 1, NOP, 32'h4);
        drive(1, 5'd30, 32'd9, 1, NOP, 32'h8);
        drive(1, 5'd31, 32'd2, 1, NOP, 32'h10);
        n_total++; if ({fail, err_code, fail_pc} !== {1'b1, 3'd1, 32'h10}) $display("[TB] FAIL samecycle_mismatch: got %b/%0d/%0h expected 1/1/10", fail, err_code, fail_pc); else n_pass++;
    endtask

    task automatic test_write_before_retire();
        do_reset();
        drive(1, 5'd1, 32'd5, 0, NOP, 32'h0);
        drive(1, 5'd31, 32'd5, 1, NOP, 32'h4);
        n_total++; if ({done, test_count} !== {1'b0, 16'd0}) $display("[TB] FAIL wbr_no_error: got %b/%0d expected 0/0", done, test_count); else n_pass++;
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h8);
        n_total++; if ({pass, err_code} !== {1'b1, 3'd0}) $display("[TB] FAIL wbr_pass: got %b/%0d expected 1/0", pass, err_code); else n_pass++;
    endtask

    task automatic test_test_count();
        do_reset();
        drive(1, 5'd1, 32'd1, 1, NOP, 32'h0);
        drive(1, 5'd1, 32'd1, 1, NOP, 32'h4);
        drive(1, 5'd1, 32'd2, 1, NOP, 32'h8);
        drive(1, 5'd0, 32'd7, 1, NOP, 32'hC);
        drive(1, 5'd31, 32'd2, 1, NOP, 32'h10);
        n_total++; if ({done, test_count} !== {1'b0, 16'd2}) $display("[TB] FAIL count_distinct: got %b/%0d expected 0/2", done, test_count); else n_pass++;
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h14);
        n_total++; if ({pass, retired_count} !== {1'b1, 32'd6}) $display("[TB] FAIL count_pass: got %b/%0d expected 1/6", pass, retired_count); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 5'd0, 32'd0, 1, NOP, 32'h8);
        for (int i = 0; i < 3; i++) cycle();
        drive(0, 5'd0, 32'd0, 1, NOP, 32'h10);
        n_total++; if (done !== 1'b0) $display("[TB] FAIL stall_three_idle_ok: got %b expected 0", done); else n_pass++;
        for (int i = 0; i < 3; i++) cycle();
        n_total++; if (done !== 1'b0) $display("[TB] FAIL stall_not_yet: got %b expected 0", done); else n_pass++;
        cycle();
        n_total++; if ({fail, err_code} !== {1'b1, 3'd5}) $display("[TB] FAIL stall_err: got %b/%0d expected 1/5", fail, err_code); else n_pass++;
        n_total++; if ({fail_pc, retired_count} !== {32'h10, 32'd2}) $display("[TB] FAIL stall_info: got %0h/%0d expected 10/2", fail_pc, retired_count); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 5'd0, 32'd0, 1, NOP, 32'(4 * i));
        n_total++; if ({done, retired_count} !== {1'b0, 32'd7}) $display("[TB] FAIL timeout_not_yet: got %b/%0d expected 0/7", done, retired_count); else n_pass++;
        drive(0, 5'd0, 32'd0, 1, NOP, 32'h1C);
        n_total++; if ({fail, err_code} !== {1'b1, 3'd4}) $display("[TB] FAIL timeout_err: got %b/%0d expected 1/4", fail, err_code); else n_pass++;
        n_total++; if ({fail_pc, retired_count} !== {32'h1C, 32'd8}) $display("[TB] FAIL timeout_info: got %0h/%0d expected 1c/8", fail_pc, retired_count); else n_pass++;
        // Sentinel on the last budgeted retire still passes.
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 5'd0, 32'd0, 1, NOP, 32'(4 * i));
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h1C);
        n_total++; if ({pass, fail, err_code} !== 5'b10_000) $display("[TB] FAIL timeout_end_boundary: got %b expected 10000", {pass, fail, err_code}); else n_pass++;
    endtask

    task automatic test_incomplete();
        do_reset();
        drive(1, 5'd1, 32'd6, 1, NOP, 32'h0);
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h4);
        n_total++; if ({fail, err_code} !== {1'b1, 3'd3}) $display("[TB] FAIL incomplete_err: got %b/%0d expected 1/3", fail, err_code); else n_pass++;
        n_total++; if ({fail_test, fail_pc} !== {32'd6, 32'h4}) $display("[TB] FAIL incomplete_info: got %0h/%0h expected 6/4", fail_test, fail_pc); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 5'd1, 32'(i + 1), 1, NOP, 32'(4 * i));
        n_total++; if ({retired_count, test_count} !== {32'd5, 16'd5}) $display("[TB] FAIL midrun_counts: got %0d/%0d expected 5/5", retired_count, test_count); else n_pass++;
        reset = 1'b0;
        cycle();
        n_total++; if ({done, pass, fail, err_code} !== 6'd0) $display("[TB] FAIL midrun_reset_flags: got %b expected 000000", {done, pass, fail, err_code}); else n_pass++;
        n_total++; if ({retired_count, test_count, fail_test, fail_pc} !== 112'd0) $display("[TB] FAIL midrun_reset_regs: got %0d/%0d/%0h/%0h expected all 0", retired_count, test_count, fail_test, fail_pc); else n_pass++;
        reset = 1'b1;
        cycle();
        drive(1, 5'd1, 32'd1, 1, NOP, 32'h0);
        drive(1, 5'd29, 32'd5, 1, NOP, 32'h4);
        drive(1, 5'd30, 32'd5, 1, NOP, 32'h8);
        drive(1, 5'd31, 32'd1, 1, NOP, 32'hC);
        drive(0, 5'd0, 32'd0, 1, EBRK, 32'h10);
        n_total++; if ({pass, err_code, retired_count} !== {1'b1, 3'd0, 32'd5}) $display("[TB] FAIL midrun_resume_pass: got %b/%0d/%0d expected 1/0/5", pass, err_code, retired_count); else n_pass++;
        reset = 1'b0;
        cycle();
        n_total++; if ({done, pass} !== 2'b00) $display("[TB] FAIL verdict_cleared: got %b expected 00", {done, pass}); else n_pass++;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = '0;
        retire = 1'b0; instr = NOP; pc = '0;
        test_reset();
        test_pass();
        test_mismatch();
        test_takeover();
        test_write_before_retire();
        test_test_count();
        test_stall();
        test_timeout();
        test_incomplete();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/assembly_test_monitor.md
Name: assembly_test_monitor

Overview:
- Synthesizable in-SoC checker that replaces the bench-side pass/fail probing of assembly self-tests.
- Snoops the CPU register-file write port and the retire strobe, and keeps shadow copies of the test-number, result, benchmark and check registers.
- Issues a sticky verdict with an error code, failing test number and PC.
- Generalises the check to configurable register indices, multi-cycle CPUs (stall watchdog), a retire budget and a sentinel end instruction.

Parameters:
- XLEN, 32, data/PC width
- TEST_REG, 1, index of the sub-test number register
- RESULT_REG, 29, index of the as-is result register
- BENCH_REG, 30, index of the expected-value register
- CHECK_REG, 31, index of the check-enable register
- MAX_RETIRED, 1024, retire budget before TIMEOUT
- STALL_LIMIT, 16, max consecutive RUN cycles without retire (0 disables)
- END_INSTR, 32'h00100073, sentinel instruction (ebreak) marking program end

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 clears all state at the clk edge
- rf_we  in  1  register-file write enable
- rf_waddr  in  5  write address
- rf_wdata  in  XLEN  write data
- retire  in  1  one instruction completes this cycle
- instr  in  32  instruction being retired
- pc  in  XLEN  PC of the retiring instruction
- done  out  1  verdict reached (sticky)
- pass  out  1  done with no error
- fail  out  1  done with error
- err_code  out  3  0 none, 1 MISMATCH, 2 TAKEOVER, 3 INCOMPLETE, 4 TIMEOUT, 5 STALL
- fail_test  out  XLEN  shadow TEST_REG value at failure
- fail_pc  out  XLEN  pc at failure
- test_count  out  16  distinct sub-tests entered
- retired_count  out  XLEN  instructions retired

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; all shadows 0.
  - Every output 0: done, pass, fail, err_code, fail_test, fail_pc, test_count, retired_count.
  - Applies mid-run and after a verdict; the verdict is lost.
- IDLE -> RUN on the first clk edge with reset==1.
- Shadows:
  - Updated at the clk edge when rf_we==1 and rf_waddr matches an index.
  - Writes to x0 are ignored.
  - An index coinciding with 0 leaves that shadow permanently 0.
- Next-shadow values are the shadows with the same-cycle write merged in. All checks use next-shadow values.
- Each retire cycle in RUN:
  - retired_count increments.
  - If next TEST != TEST and a TEST write occurs, test_count increments (saturates at 16'hFFFF).
  - If next CHECK != 0:
    - CHECK != TEST -> TAKEOVER.
    - Else RESULT != BENCH (full XLEN, case-equal) -> MISMATCH.
  - If instr == END_INSTR:
    - Any prior error takes precedence.
    - Next TEST != 0 and next CHECK != next TEST -> INCOMPLETE (a test was started but never checked).
    - Otherwise -> PASS.
  - If retired_count+1 >= MAX_RETIRED and no END_INSTR -> TIMEOUT.
- Stall watchdog:
  - Counts RUN cycles with retire==0 and clears on retire.
  - Reaching STALL_LIMIT -> STALL.
- Priority for simultaneous errors: TAKEOVER > MISMATCH > INCOMPLETE > TIMEOUT > STALL. PASS is only taken with no error.
- Latency: the verdict is registered at the edge that ends the offending cycle, so outputs are visible in the next cycle.
  - fail_test = next TEST.
  - fail_pc = pc of the offending cycle. For STALL, fail_pc is the pc of the last retire.
- Terminal states:
  - PASS and FAIL are terminal and sticky; inputs are ignored.
  - Counters freeze; done=1.
  - Exactly one of pass/fail is set.
- retire==0 cycles never run checks. Register writes without retire still update shadows, which supports multi-cycle write-before-retire.

Decomposition:
- rtl/parameters.vh gets:
  - the err_code localparams ERR_NONE..ERR_STALL;
  - the state encodings IDLE/RUN/PASS/FAIL (2 bits);
  - the default END_INSTR.
- One sub-module: assembly_test_watchdog.
  - Parametrised saturating counter with clear and enable.
  - Asserts expired at STALL_LIMIT; disabled when STALL_LIMIT==0.
  - Same clk and active-low synchronous reset.

Test Plan:
- Pass: x1=1; x29=x30=5; x31=1 retired; then END_INSTR -> pass=1, err_code=0, test_count=1, done one cycle after the end retire.
- Mismatch: x1=3; x29=7; x30=8; x31=3 retired at pc=0x40 -> fail=1, err_code=1, fail_test=3, fail_pc=0x40. Later writes leave the outputs unchanged.
- Takeover plus same-cycle write: x1=2, then a retire writing x31=4 with x29!=x30 -> err_code=2 (TAKEOVER beats MISMATCH). A same-cycle write is seen by the check.
- Stall: STALL_LIMIT=4; retire at pc=0x10, then 4 idle cycles -> err_code=5, fail_pc=0x10. With 3 idle cycles and then a retire -> no error.
- Timeout and incomplete:
  - MAX_RETIRED=8, no sentinel -> err_code=4 on the 8th retire.
  - Separately, x1=6 with x31 never set, then END_INSTR -> err_code=3, fail_test=6.
- Reset mid-run: hold reset=0 for one edge during RUN with retired_count=5 -> all outputs 0. RUN resumes and a subsequent passing sequence reaches pass=1.
